// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the recorder (writes) and the DSP (reads).
// Round-robin grant, fixed-length accesses, one IDLE turnaround cycle between them.
module sram_arbiter #(
   parameter int unsigned ACC_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rec_req,
   input  logic [19:0] i_rec_addr,
   input  logic [15:0] i_rec_wdata,
   output logic        o_rec_ack,
   input  logic        i_dsp_req,
   input  logic [19:0] i_dsp_addr,
   output logic        o_dsp_ack,
   output logic [15:0] o_dsp_rdata,
   output logic [19:0] o_SRAM_ADDR,
   output logic        o_SRAM_WE_N,
   output logic        o_SRAM_CE_N,
   output logic        o_SRAM_OE_N,
   output logic        o_SRAM_LB_N,
   output logic        o_SRAM_UB_N,
   output logic        o_dq_oe,
   output logic [15:0] o_dq_out,
   input  logic [15:0] i_dq_in,
   output logic        o_busy
);

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   localparam logic [3:0] LAST = 4'(ACC_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       last_rec;
   logic       rec_ok;
   logic       dsp_ok;
   logic       pick_rec;

   // a requester that is being acked this cycle has not yet seen its ack
   assign rec_ok   = i_rec_req & ~o_rec_ack;
   assign dsp_ok   = i_dsp_req & ~o_dsp_ack;
   assign pick_rec = rec_ok & (~dsp_ok | ~last_rec);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         last_rec    <= 1'b0;
         o_rec_ack   <= 1'b0;
         o_dsp_ack   <= 1'b0;
         o_dsp_rdata <= '0;
         o_SRAM_ADDR <= '0;
         o_SRAM_WE_N <= 1'b1;
         o_SRAM_CE_N <= 1'b1;
         o_SRAM_OE_N <= 1'b1;
         o_SRAM_LB_N <= 1'b1;
         o_SRAM_UB_N <= 1'b1;
         o_dq_oe     <= 1'b0;
         o_dq_out    <= '0;
         o_busy      <= 1'b0;
      end else begin
         o_rec_ack <= 1'b0;
         o_dsp_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (rec_ok | dsp_ok) begin
                  cnt         <= '0;
                  o_busy      <= 1'b1;
                  o_SRAM_CE_N <= 1'b0;
                  o_SRAM_LB_N <= 1'b0;
                  o_SRAM_UB_N <= 1'b0;
                  if (pick_rec) begin
                     state       <= WRITE;
                     last_rec    <= 1'b1;
                     o_SRAM_ADDR <= i_rec_addr;
                     o_dq_out    <= i_rec_wdata;
                     o_SRAM_WE_N <= 1'b0;
                     o_dq_oe     <= 1'b1;
                  end else begin
                     state       <= READ;
                     last_rec    <= 1'b0;
                     o_SRAM_ADDR <= i_dsp_addr;
                     o_SRAM_OE_N <= 1'b0;
                  end
               end
            end
            WRITE, READ: begin
               if (cnt == LAST) begin
                  state       <= IDLE;
                  o_busy      <= 1'b0;
                  o_SRAM_WE_N <= 1'b1;
                  o_SRAM_CE_N <= 1'b1;
                  o_SRAM_OE_N <= 1'b1;
                  o_SRAM_LB_N <= 1'b1;
                  o_SRAM_UB_N <= 1'b1;
                  o_dq_oe     <= 1'b0;
                  if (state == READ) begin
                     o_dsp_rdata <= i_dq_in;
                     o_dsp_ack   <= 1'b1;
                  end else begin
                     o_rec_ack   <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model with an SRAM behaviour model on the bus.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rec_req = 1'b0;
   logic [19:0] rec_addr = '0;
   logic [15:0] rec_wdata = '0;
   logic        dsp_req = 1'b0;
   logic [19:0] dsp_addr = '0;
   logic        rec_ack, dsp_ack, busy;
   logic [15:0] dsp_rdata, dq_out, dq_in;
   logic [19:0] sram_addr;
   logic        we_n, ce_n, oe_n, lb_n, ub_n, dq_oe;

   logic        x1_rec_req = 1'b0;
   logic        x1_dsp_req = 1'b0;
   logic        x1_rec_ack, x1_dsp_ack, x1_busy;
   logic [15:0] x1_rdata, x1_dq_out;
   logic [19:0] x1_addr;
   logic        x1_we_n, x1_ce_n, x1_oe_n, x1_lb_n, x1_ub_n, x1_dq_oe;

   logic        x15_rec_req = 1'b0;
   logic        x15_dsp_req = 1'b0;
   logic        x15_rec_ack, x15_dsp_ack, x15_busy;
   logic [15:0] x15_rdata, x15_dq_out;
   logic [19:0] x15_addr;
   logic        x15_we_n, x15_ce_n, x15_oe_n, x15_lb_n, x15_ub_n, x15_dq_oe;

   logic        dq_ovr = 1'b0;
   logic [15:0] dq_ovr_val = '0;
   logic [15:0] sram [256];
   logic [15:0] ref_mem [256];

   int n_chk = 0;
   int n_fail = 0;

   int          m_owner = 0;
   int          m_left = 0;
   logic        m_ack_rec = 1'b0;
   logic        m_ack_dsp = 1'b0;
   logic        m_last_rec = 1'b0;
   logic [19:0] m_addr = '0;
   logic [15:0] m_dq_out = '0;
   logic [15:0] m_rdata = '0;

   always #5 clk = ~clk;

   sram_arbiter #(.ACC_CYCLES(2)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_rec_req(rec_req), .i_rec_addr(rec_addr), .i_rec_wdata(rec_wdata),
      .o_rec_ack(rec_ack),
      .i_dsp_req(dsp_req), .i_dsp_addr(dsp_addr),
      .o_dsp_ack(dsp_ack), .o_dsp_rdata(dsp_rdata),
      .o_SRAM_ADDR(sram_addr), .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n),
      .o_SRAM_OE_N(oe_n), .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n),
      .o_dq_oe(dq_oe), .o_dq_out(dq_out), .i_dq_in(dq_in),
      .o_busy(busy)
   );

   sram_arbiter #(.ACC_CYCLES(1)) u_a1 (
      .i_clk(clk), .i_rst(rst),
      .i_rec_req(x1_rec_req), .i_rec_addr(rec_addr), .i_rec_wdata(rec_wdata),
      .o_rec_ack(x1_rec_ack),
      .i_dsp_req(x1_dsp_req), .i_dsp_addr(dsp_addr),
      .o_dsp_ack(x1_dsp_ack), .o_dsp_rdata(x1_rdata),
      .o_SRAM_ADDR(x1_addr), .o_SRAM_WE_N(x1_we_n), .o_SRAM_CE_N(x1_ce_n),
      .o_SRAM_OE_N(x1_oe_n), .o_SRAM_LB_N(x1_lb_n), .o_SRAM_UB_N(x1_ub_n),
      .o_dq_oe(x1_dq_oe), .o_dq_out(x1_dq_out), .i_dq_in(16'h5A5A),
      .o_busy(x1_busy)
   );

   sram_arbiter #(.ACC_CYCLES(15)) u_a15 (
      .i_clk(clk), .i_rst(rst),
      .i_rec_req(x15_rec_req), .i_rec_addr(rec_addr), .i_rec_wdata(rec_wdata),
      .o_rec_ack(x15_rec_ack),
      .i_dsp_req(x15_dsp_req), .i_dsp_addr(dsp_addr),
      .o_dsp_ack(x15_dsp_ack), .o_dsp_rdata(x15_rdata),
      .o_SRAM_ADDR(x15_addr), .o_SRAM_WE_N(x15_we_n), .o_SRAM_CE_N(x15_ce_n),
      .o_SRAM_OE_N(x15_oe_n), .o_SRAM_LB_N(x15_lb_n), .o_SRAM_UB_N(x15_ub_n),
      .o_dq_oe(x15_dq_oe), .o_dq_out(x15_dq_out), .i_dq_in(16'h5A5A),
      .o_busy(x15_busy)
   );

   // SRAM behaviour: writes land on strobed edges, reads are combinational
   always @(posedge clk)
      if (!ce_n && !we_n) sram[sram_addr[7:0]] <= dq_out;

   always_comb begin
      dq_in = 16'hDEAD;
      if (dq_ovr) dq_in = dq_ovr_val;
      else if (!ce_n && !oe_n) dq_in = sram[sram_addr[7:0]];
   end

   // transaction model: owner 0 none, 1 recorder, 2 DSP
   always @(negedge clk) begin
      logic [6:0] exp_s;
      logic [6:0] got_s;
      logic       er, ed, nar, nad;
      if (rst) begin
         m_owner = 0; m_left = 0; m_ack_rec = 0; m_ack_dsp = 0;
         m_last_rec = 0; m_addr = '0; m_dq_out = '0; m_rdata = '0;
      end
      exp_s = {m_owner != 1, m_owner == 0, m_owner != 2, m_owner == 0,
               m_owner == 0, m_owner == 1, m_owner != 0};
      got_s = {we_n, ce_n, oe_n, lb_n, ub_n, dq_oe, busy};
      n_chk++;
      if (got_s !== exp_s) begin
         n_fail++;
         $display("FAIL mon_strobes t=%0t got %b exp %b", $time, got_s, exp_s);
      end
      n_chk++;
      if (sram_addr !== m_addr) begin
         n_fail++;
         $display("FAIL mon_addr t=%0t got %h exp %h", $time, sram_addr, m_addr);
      end
      n_chk++;
      if (dq_out !== m_dq_out) begin
         n_fail++;
         $display("FAIL mon_dq_out t=%0t got %h exp %h", $time, dq_out, m_dq_out);
      end
      n_chk++;
      if (dsp_rdata !== m_rdata) begin
         n_fail++;
         $display("FAIL mon_rdata t=%0t got %h exp %h", $time, dsp_rdata, m_rdata);
      end
      n_chk++;
      if ({rec_ack, dsp_ack} !== {m_ack_rec, m_ack_dsp}) begin
         n_fail++;
         $display("FAIL mon_acks t=%0t got %b exp %b", $time,
                  {rec_ack, dsp_ack}, {m_ack_rec, m_ack_dsp});
      end
      if (!rst) begin
         nar = 1'b0;
         nad = 1'b0;
         if (m_owner == 0) begin
            er = rec_req && !m_ack_rec;
            ed = dsp_req && !m_ack_dsp;
            if (er && (!ed || !m_last_rec)) begin
               m_owner = 1; m_left = 2; m_last_rec = 1;
               m_addr = rec_addr; m_dq_out = rec_wdata;
            end else if (ed) begin
               m_owner = 2; m_left = 2; m_last_rec = 0;
               m_addr = dsp_addr;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               if (m_owner == 1) begin
                  ref_mem[m_addr[7:0]] = m_dq_out;
                  nar = 1'b1;
               end else begin
                  m_rdata = dq_ovr ? dq_ovr_val : ref_mem[m_addr[7:0]];
                  nad = 1'b1;
               end
               m_owner = 0;
            end
         end
         m_ack_rec = nar;
         m_ack_dsp = nad;
      end
   end

   task automatic wait_edge;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [6:0] s;
      rst = 1'b1;
      repeat (2) wait_edge();
      s = {we_n, ce_n, oe_n, lb_n, ub_n, dq_oe, busy};
      n_chk++;
      if (s !== 7'b1111100) begin
         n_fail++;
         $display("FAIL reset_strobes got %b exp %b", s, 7'b1111100);
      end
      n_chk++;
      if ({sram_addr, dq_out, dsp_rdata, rec_ack, dsp_ack} !== 54'd0) begin
         n_fail++;
         $display("FAIL reset_data got %h/%h/%h/%b%b exp 0",
                  sram_addr, dq_out, dsp_rdata, rec_ack, dsp_ack);
      end
      rst = 1'b0;
      repeat (2) wait_edge();
   endtask

   task automatic test_write;
      rec_addr = 20'h00010;
      rec_wdata = 16'hBEEF;
      rec_req = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         wait_edge();
         n_chk++;
         if ({we_n, dq_oe, busy} !== ((c <= 2) ? 3'b011 : 3'b100)) begin
            n_fail++;
            $display("FAIL write_strobe c=%0d got %b", c, {we_n, dq_oe, busy});
         end
         if (c <= 2) begin
            n_chk++;
            if ({sram_addr, dq_out} !== {20'h00010, 16'hBEEF}) begin
               n_fail++;
               $display("FAIL write_bus c=%0d got %h %h exp 00010 beef",
                        c, sram_addr, dq_out);
            end
         end
         n_chk++;
         if (rec_ack !== (c == 3)) begin
            n_fail++;
            $display("FAIL write_ack c=%0d got %b exp %b", c, rec_ack, c == 3);
         end
         if (c == 3) rec_req = 1'b0;
      end
      repeat (2) wait_edge();
   endtask

   task automatic test_read;
      dsp_addr = 20'h00010;
      dq_ovr = 1'b1;
      dq_ovr_val = 16'h1234;
      dsp_req = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         wait_edge();
         n_chk++;
         if ({oe_n, we_n, dq_oe} !== ((c <= 2) ? 3'b010 : 3'b110)) begin
            n_fail++;
            $display("FAIL read_strobe c=%0d got %b", c, {oe_n, we_n, dq_oe});
         end
         n_chk++;
         if (dsp_ack !== (c == 3)) begin
            n_fail++;
            $display("FAIL read_ack c=%0d got %b exp %b", c, dsp_ack, c == 3);
         end
         if (c >= 3) begin
            n_chk++;
            if (dsp_rdata !== 16'h1234) begin
               n_fail++;
               $display("FAIL read_data c=%0d got %h exp 1234", c, dsp_rdata);
            end
         end
         if (c == 3) begin
            dsp_req = 1'b0;
            dq_ovr = 1'b0;
         end
      end
      repeat (2) wait_edge();
   endtask

   task automatic test_round_robin;
      int got, exp;
      rst = 1'b1;
      wait_edge();
      rst = 1'b0;
      rec_addr = 20'($urandom_range(15));
      rec_wdata = 16'($urandom);
      dsp_addr = 20'($urandom_range(15));
      rec_req = 1'b1;
      dsp_req = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         wait_edge();
         got = !we_n ? 1 : (!oe_n ? 2 : 0);
         exp = (i % 3 == 0) ? 0 : ((((i - 1) / 3) % 2 == 0) ? 1 : 2);
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL rr_order i=%0d got %0d exp %0d", i, got, exp);
         end
         n_chk++;
         if ((dq_oe & ~oe_n) !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_overlap i=%0d got dq_oe=%b oe_n=%b", i, dq_oe, oe_n);
         end
      end
      rec_req = 1'b0;
      dsp_req = 1'b0;
      repeat (2) wait_edge();
   endtask

   task automatic test_reset_mid;
      int first, got_rec, got_dsp;
      rec_addr = 20'h00020;
      rec_wdata = 16'($urandom);
      rec_req = 1'b1;
      wait_edge();
      n_chk++;
      if (we_n !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_pre got we_n=%b exp 0", we_n);
      end
      rst = 1'b1;
      dsp_addr = 20'h00020;
      dsp_req = 1'b1;
      #1;
      n_chk++;
      if ({we_n, ce_n, oe_n, lb_n, ub_n, dq_oe, busy} !== 7'b1111100) begin
         n_fail++;
         $display("FAIL rmid_abort got %b exp 1111100",
                  {we_n, ce_n, oe_n, lb_n, ub_n, dq_oe, busy});
      end
      for (int c = 0; c < 2; c++) begin
         wait_edge();
         n_chk++;
         if (rec_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_noack c=%0d got %b exp 0", c, rec_ack);
         end
      end
      rst = 1'b0;
      first = 0;
      got_rec = 0;
      got_dsp = 0;
      for (int c = 0; c < 12 && (got_rec == 0 || got_dsp == 0); c++) begin
         wait_edge();
         if (first == 0 && !we_n) first = 1;
         else if (first == 0 && !oe_n) first = 2;
         if (rec_ack && rec_req) begin rec_req = 1'b0; got_rec++; end
         if (dsp_ack && dsp_req) begin dsp_req = 1'b0; got_dsp++; end
      end
      n_chk++;
      if (first !== 1) begin
         n_fail++;
         $display("FAIL rmid_first got %0d exp 1", first);
      end
      n_chk++;
      if ({got_rec, got_dsp} !== {32'd1, 32'd1}) begin
         n_fail++;
         $display("FAIL rmid_done got rec=%0d dsp=%0d exp 1 1", got_rec, got_dsp);
      end
      rec_req = 1'b0;
      dsp_req = 1'b0;
      repeat (2) wait_edge();
   endtask

   task automatic test_drop;
      int reads, acks;
      reads = 0;
      acks = 0;
      dsp_addr = 20'h00005;
      dsp_req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         wait_edge();
         if (!oe_n) reads++;
         if (dsp_ack) acks++;
         if (c == 1) dsp_req = 1'b0;
      end
      n_chk++;
      if (reads !== 2) begin
         n_fail++;
         $display("FAIL drop_reads got %0d exp 2", reads);
      end
      n_chk++;
      if (acks !== 1) begin
         n_fail++;
         $display("FAIL drop_acks got %0d exp 1", acks);
      end
   endtask

   task automatic test_latency;
      int lat, low;
      rec_addr = 20'h00033;
      rec_wdata = 16'hA1B2;
      x1_rec_req = 1'b1;
      lat = 0;
      low = 0;
      for (int n = 1; n <= 20; n++) begin
         wait_edge();
         if (!x1_we_n) low++;
         if (x1_rec_ack) begin lat = n; break; end
      end
      x1_rec_req = 1'b0;
      n_chk++;
      if ({lat, low} !== {32'd2, 32'd1}) begin
         n_fail++;
         $display("FAIL lat_acc1 got lat=%0d we_low=%0d exp 2 1", lat, low);
      end
      n_chk++;
      if ({x1_we_n, x1_ce_n, x1_oe_n, x1_lb_n, x1_ub_n, x1_dq_oe, x1_busy,
           x1_dsp_ack, x1_addr, x1_dq_out, x1_rdata} !==
          {8'b11111000, 20'h00033, 16'hA1B2, 16'h0000}) begin
         n_fail++;
         $display("FAIL lat_acc1_idle got %b %h %h %h",
                  {x1_we_n, x1_ce_n, x1_oe_n, x1_lb_n, x1_ub_n, x1_dq_oe,
                   x1_busy, x1_dsp_ack}, x1_addr, x1_dq_out, x1_rdata);
      end
      dsp_addr = 20'h00044;
      x15_dsp_req = 1'b1;
      lat = 0;
      low = 0;
      for (int n = 1; n <= 30; n++) begin
         wait_edge();
         if (!x15_oe_n) low++;
         if (x15_dsp_ack) begin lat = n; break; end
      end
      x15_dsp_req = 1'b0;
      n_chk++;
      if ({lat, low} !== {32'd16, 32'd15}) begin
         n_fail++;
         $display("FAIL lat_acc15 got lat=%0d oe_low=%0d exp 16 15", lat, low);
      end
      n_chk++;
      if ({x15_we_n, x15_ce_n, x15_oe_n, x15_lb_n, x15_ub_n, x15_dq_oe,
           x15_busy, x15_rec_ack, x15_addr, x15_dq_out, x15_rdata} !==
          {8'b11111000, 20'h00044, 16'h0000, 16'h5A5A}) begin
         n_fail++;
         $display("FAIL lat_acc15_idle got %b %h %h %h",
                  {x15_we_n, x15_ce_n, x15_oe_n, x15_lb_n, x15_ub_n, x15_dq_oe,
                   x15_busy, x15_rec_ack}, x15_addr, x15_dq_out, x15_rdata);
      end
      repeat (2) wait_edge();
   endtask

   task automatic test_random;
      for (int c = 0; c < 800; c++) begin
         wait_edge();
         if (rec_req && rec_ack) begin
            if ($urandom_range(1) == 1) begin
               rec_addr = 20'($urandom_range(15));
               rec_wdata = 16'($urandom);
            end else rec_req = 1'b0;
         end else if (!rec_req && $urandom_range(2) == 0) begin
            rec_req = 1'b1;
            rec_addr = 20'($urandom_range(15));
            rec_wdata = 16'($urandom);
         end else if (rec_req && !we_n && $urandom_range(7) == 0) begin
            rec_req = 1'b0;
         end
         if (dsp_req && dsp_ack) begin
            if ($urandom_range(1) == 1) dsp_addr = 20'($urandom_range(15));
            else dsp_req = 1'b0;
         end else if (!dsp_req && $urandom_range(2) == 0) begin
            dsp_req = 1'b1;
            dsp_addr = 20'($urandom_range(15));
         end else if (dsp_req && !oe_n && $urandom_range(7) == 0) begin
            dsp_req = 1'b0;
         end
      end
      rec_req = 1'b0;
      dsp_req = 1'b0;
      repeat (8) wait_edge();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         sram[i] = 16'hC000 | 16'(i);
         ref_mem[i] = 16'hC000 | 16'(i);
      end
      #1;
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_reset_mid();
      test_drop();
      test_latency();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Parameters
REQ-001 SHALL provide ACC_CYCLES, default 2, meaning SRAM access length in clock cycles; legal range 1..15.

Interface
REQ-002 SHALL have these ports: i_clk  in  1  system clock (12 MHz audio clock); all logic is rising-edge.
REQ-003 SHALL have these ports: i_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have these ports: i_rec_req  in  1  recorder write request; level, held until ack.
REQ-005 SHALL have these ports: i_rec_addr  in  20  write word address; i_rec_wdata  in  16  write data.
REQ-006 SHALL have these ports: o_rec_ack  out  1  one-cycle pulse, write completed.
REQ-007 SHALL have these ports: i_dsp_req  in  1  DSP read request; level, held until ack.
REQ-008 SHALL have these ports: i_dsp_addr  in  20  read word address.
REQ-009 SHALL have these ports: o_dsp_ack  out  1  one-cycle pulse, read data valid; o_dsp_rdata  out  16  read data.
REQ-010 SHALL have these ports: o_SRAM_ADDR  out  20; o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each.
REQ-011 SHALL have these ports: o_dq_oe  out  1  DQ drive enable; o_dq_out  out  16  DQ drive value; i_dq_in  in  16  DQ sampled value. Tristating happens at the top level.
REQ-012 SHALL have these ports: o_busy  out  1  high while not in IDLE.
REQ-013 SHALL register every output; no combinational path from input to output.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, READ.
REQ-015 In IDLE, with any eligible request, SHALL register the granted address (and wdata for a write) and enter WRITE or READ on the next edge.
REQ-016 Arbitration SHALL be round-robin.
- Both requesting: grant the requester not granted last.
- Single requester: grant it.
- Pointer updates on each grant.
- After reset, recorder wins first.
REQ-017 A requester whose ack is high in the current cycle SHALL be ineligible that cycle. Requesters drop or renew req after seeing ack.
REQ-018 WRITE SHALL last exactly ACC_CYCLES cycles with these outputs:
- CE_N=0, WE_N=0, OE_N=1
- LB_N=UB_N=0
- dq_oe=1
- dq_out=latched wdata
- ADDR=latched address
REQ-019 READ SHALL last exactly ACC_CYCLES cycles with these outputs:
- CE_N=0, OE_N=0, WE_N=1
- LB_N=UB_N=0
- dq_oe=0
REQ-020 On the final READ edge, SHALL capture i_dq_in into o_dsp_rdata. o_dsp_rdata holds until the next read completes.
REQ-021 On leaving WRITE/READ, SHALL return to IDLE and pulse the matching ack high for exactly the one IDLE cycle.
REQ-022 Latency: request sampled at edge k yields ack high in cycle k+ACC_CYCLES+1. Back-to-back accesses SHALL be separated by at least one IDLE cycle.
REQ-023 In IDLE, SHALL drive:
- WE_N=1, OE_N=1, CE_N=1
- LB_N=UB_N=1
- dq_oe=0
- ADDR holding its last value
This IDLE cycle is the bus turnaround between a write and a read.
REQ-024 dq_oe and WE_N SHALL never be low/high inconsistently: dq_oe=1 only in WRITE, OE_N=0 only in READ, never both.
REQ-025 SHALL ignore request changes during WRITE/READ. Dropping req mid-access does not abort it; ack still pulses.
REQ-026 The access counter SHALL be 4 bits, count 0..ACC_CYCLES-1, and clear on each grant.

Reset
REQ-027 On i_rst high, asynchronously and regardless of state, SHALL set:
- FSM to IDLE
- all SRAM strobes to 1, dq_oe=0
- ADDR=0, dq_out=0, o_dsp_rdata=0
- both acks=0, o_busy=0
- round-robin pointer to "DSP last"
REQ-028 Reset mid-access SHALL abort the access without generating an ack. The first grant after release follows REQ-015/016.

Verification
REQ-029 ACC_CYCLES=2, rec_req with addr 0x00010 and wdata 0xBEEF at edge 0 -> WE_N=0, dq_oe=1, ADDR=0x00010, dq_out=0xBEEF in cycles 1-2; o_rec_ack=1 in cycle 3 only.
REQ-030 dsp_req with addr 0x00010 and i_dq_in=0x1234 -> OE_N=0 for 2 cycles; o_dsp_ack=1 with o_dsp_rdata=0x1234 in cycle 3.
REQ-031 Both reqs continuously high from reset -> grant order rec, dsp, rec, dsp; every access separated by exactly one IDLE cycle; dq_oe never overlaps OE_N=0.
REQ-032 i_rst asserted during cycle 1 of a WRITE -> all strobes high and dq_oe=0 immediately; no o_rec_ack; after release a pending dsp_req is not granted before a pending rec_req.
REQ-033 dsp_req dropped after 1 cycle of READ -> READ completes; o_dsp_ack pulses once; no second read issued.
REQ-034 ACC_CYCLES=1 and 15 -> ack latency of 2 and 16 cycles respectively.
